ps2_host_ctrl: RTL and testbench

Parametrised bidirectional PS/2 host controller: filters the PS/2 clock, receives 11-bit device frames into a small RX FIFO with parity/framing checks, and transmits host-to-device command bytes with inhibit, request-to-send and ACK checking. Sits between the open-drain `ps2_c`/`ps2_d` pads and the keyboard/mouse decode logic. Replaces the fixed 8-bit-filter, unbuffered, receive-biased controller with configurable timing, buffering and error reporting.

---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_clk_filter.sv | 27 ++
 rtl/ps2_host_ctrl.sv | 151 +++++++++++++++
 tb/tb_ps2_host_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, frame constants and parity helper for the PS/2 host controller
package ps2_pkg;
    localparam int FRAME_BITS      = 11;
    localparam int DEF_FILTER_LEN  = 8;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_INHIBIT_CYC = 5000;
    localparam int DEF_TIMEOUT_CYC = 100000;

    typedef enum logic [2:0] {TX_IDLE, TX_INHIBIT, TX_RTS, TX_SEND, TX_ACK} tx_state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronises and debounces the PS/2 clock, flags filtered falling edges
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_c_in,
    output logic fall_edge
);
    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] sr;
    logic                  level;

    assign fall_edge = level && ~|sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= 2'b11;
            sr    <= '1;
            level <= 1'b1;
        end else begin
            sync  <= {sync[0], ps2_c_in};
            sr    <= {sr[FILTER_LEN-2:0], sync[1]};
            level <= &sr ? 1'b1 : ~|sr ? 1'b0 : level;
        end
    end
endmodule

// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl: bidirectional PS/2 host with filtered clock, buffered receive and command transmit
module ps2_host_ctrl
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        ps2_c,
    inout  wire        ps2_d,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_err,
    output logic       rx_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2((TIMEOUT_CYC > INHIBIT_CYC ? TIMEOUT_CYC : INHIBIT_CYC) + 1);

    tx_state_t             state, next;
    logic                  fall_edge, c_low, d_low, d_drv, tmr_hit, tmr_clr, tx_to, rx_to;
    logic                  rx_edge, rx_last, rx_good, push, pop, full;
    logic [1:0]            d_sync;
    logic [3:0]            bit_cnt, tx_k;
    logic [FRAME_BITS-2:0] shreg;
    logic [FRAME_BITS-1:0] frame;
    logic [8:0]            tx_sh;
    logic [TW-1:0]         tmr;
    logic [AW:0]           wp, rp;
    logic [7:0]            mem [FIFO_DEPTH];

    assign ps2_c = c_low ? 1'b0 : 1'bz;
    assign ps2_d = d_low ? 1'b0 : 1'bz;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk       (clk),
        .rst       (rst),
        .ps2_c_in  (ps2_c),
        .fall_edge (fall_edge)
    );

    // One timer serves inhibit length, in-frame timeouts for both directions
    assign tmr_hit  = tmr == TW'(TIMEOUT_CYC - 1);
    assign tmr_clr  = (state == TX_IDLE && bit_cnt == 4'd0) || state != next ||
                      (fall_edge && state != TX_INHIBIT);
    assign rx_to    = state == TX_IDLE && bit_cnt != 4'd0 && !fall_edge && tmr_hit;
    assign tx_to    = (state == TX_SEND || state == TX_ACK) && !fall_edge && tmr_hit;
    assign tx_ready = state == TX_IDLE && bit_cnt == 4'd0;

    assign rx_edge  = fall_edge && state == TX_IDLE;
    assign frame    = {d_sync[1], shreg};
    assign rx_last  = bit_cnt == 4'(FRAME_BITS - 1);
    assign rx_good  = !frame[0] && ^frame[9:1] && frame[10];

    assign full     = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign rx_valid = wp != rp;
    assign rx_data  = rx_valid ? mem[rp[AW-1:0]] : 8'h00;
    assign pop      = rx_valid && rx_ready;
    assign push     = rx_edge && rx_last && rx_good && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_sync  <= 2'b11;
            shreg   <= '0;
            bit_cnt <= 4'd0;
            tmr     <= '0;
            wp      <= '0;
            rp      <= '0;
            rx_err  <= 1'b0;
            rx_ovf  <= 1'b0;
        end else begin
            d_sync  <= {d_sync[0], ps2_d};
            tmr     <= tmr_clr ? '0 : tmr + 1'b1;
            if (rx_edge)
                shreg <= frame[FRAME_BITS-1:1];
            bit_cnt <= rx_edge ? (rx_last ? 4'd0 : bit_cnt + 4'd1) :
                       (rx_to || state != TX_IDLE) ? 4'd0 : bit_cnt;
            rx_err  <= (rx_edge && rx_last && !rx_good) || rx_to;
            rx_ovf  <= rx_edge && rx_last && rx_good && full && !pop;
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (push)
            mem[wp[AW-1:0]] <= frame[8:1];

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= TX_IDLE;
        else
            state <= next;

    always_comb begin
        next  = state;
        c_low = 1'b0;
        d_low = 1'b0;
        unique case (state)
            TX_IDLE:    next = tx_valid && tx_ready ? TX_INHIBIT : TX_IDLE;
            TX_INHIBIT: begin
                c_low = 1'b1;
                d_low = tmr == TW'(INHIBIT_CYC - 1);
                next  = d_low ? TX_RTS : TX_INHIBIT;
            end
            TX_RTS: begin
                d_low = 1'b1;
                next  = TX_SEND;
            end
            TX_SEND: begin
                d_low = d_drv;
                next  = tx_to ? TX_IDLE : fall_edge && tx_k == 4'd9 ? TX_ACK : TX_SEND;
            end
            TX_ACK:     next = tx_to || fall_edge ? TX_IDLE : TX_ACK;
            default:    next = TX_IDLE;
        endcase
    end

    // Shifting in ones means the tenth edge releases the line for the stop bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_sh   <= '0;
            tx_k    <= 4'd0;
            d_drv   <= 1'b0;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
        end else begin
            tx_done <= state == TX_ACK && fall_edge && !d_sync[1];
            tx_err  <= tx_to || (state == TX_ACK && fall_edge && d_sync[1]);
            if (state == TX_IDLE && tx_valid && tx_ready) begin
                tx_sh <= {odd_parity(tx_data), tx_data};
                tx_k  <= 4'd0;
                d_drv <= 1'b1;
            end else if (state == TX_SEND && fall_edge) begin
                tx_sh <= {1'b1, tx_sh[8:1]};
                tx_k  <= tx_k + 4'd1;
                d_drv <= !tx_sh[0];
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb_ps2_host_ctrl: directed vectors and device-model sequences for ps2_host_ctrl
module tb_ps2_host_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b0;
    logic       tx_ready, tx_done, tx_err, rx_valid, rx_err, rx_ovf;
    logic [7:0] rx_data;
    logic       dev_c = 1'b1;
    logic       dev_d = 1'b1;
    wire        ps2_c, ps2_d;

    pullup (ps2_c);
    pullup (ps2_d);
    assign ps2_c = dev_c ? 1'bz : 1'b0;
    assign ps2_d = dev_d ? 1'bz : 1'b0;

    ps2_host_ctrl #(
        .FILTER_LEN  (8),
        .FIFO_DEPTH  (4),
        .INHIBIT_CYC (5000),
        .TIMEOUT_CYC (2000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_c    (ps2_c),
        .ps2_d    (ps2_d),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .tx_err   (tx_err),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_err   (rx_err),
        .rx_ovf   (rx_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_rxerr = 0, n_ovf = 0, n_done = 0, n_txerr = 0, n_fe = 0;

    always @(posedge clk) begin
        if (rx_err)        n_rxerr <= n_rxerr + 1;
        if (rx_ovf)        n_ovf   <= n_ovf + 1;
        if (tx_done)       n_done  <= n_done + 1;
        if (tx_err)        n_txerr <= n_txerr + 1;
        if (dut.fall_edge) n_fe    <= n_fe + 1;
    end

    typedef struct {
        logic [10:0] frame;
        int          npop;
        logic        exp_valid;
        logic [7:0]  exp_head;
        logic        exp_err;
        logic        exp_ovf;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic bad_par,
                                       input logic start, input logic stop);
        return {stop, (~^d) ^ bad_par, d, start};
    endfunction

    task automatic send_frame(input logic [10:0] f);
        for (int i = 0; i < 11; i++) begin
            dev_d = f[i];
            repeat (10) @(negedge clk);
            dev_c = 1'b0;
            repeat (20) @(negedge clk);
            dev_c = 1'b1;
            repeat (10) @(negedge clk);
        end
        dev_d = 1'b1;
    endtask

    task automatic pop_one;
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        check("tx_ready_at_handshake", tx_ready, 1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic dev_rx(input int pulses, input logic ack, output logic [9:0] got,
                          output int low_len, output logic start_bit);
        low_len = 0;
        got     = '1;
        @(negedge clk);
        while (ps2_c === 1'b0 && low_len < 20000) begin
            low_len++;
            @(negedge clk);
        end
        start_bit = ps2_d;
        repeat (20) @(negedge clk);
        for (int i = 0; i < pulses; i++) begin
            if (i == 10) dev_d = ack;
            repeat (10) @(negedge clk);
            dev_c = 1'b0;
            repeat (20) @(negedge clk);
            if (i < 10) got[i] = ps2_d;
            dev_c = 1'b1;
            repeat (10) @(negedge clk);
        end
        dev_d = 1'b1;
    endtask

    initial begin
        int e0, o0, d0, t;
        int low_len;
        logic [9:0] got;
        logic start_bit;

        vecs[0] = '{mk(8'h1C, 1'b0, 1'b0, 1'b1), 1, 1'b1, 8'h1C, 1'b0, 1'b0};
        vecs[1] = '{mk(8'hF0, 1'b1, 1'b0, 1'b1), 0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{mk(8'h1C, 1'b0, 1'b0, 1'b0), 0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{mk(8'h55, 1'b0, 1'b1, 1'b1), 0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{mk(8'h01, 1'b0, 1'b0, 1'b1), 0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{mk(8'h02, 1'b0, 1'b0, 1'b1), 0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{mk(8'h03, 1'b0, 1'b0, 1'b1), 0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{mk(8'h04, 1'b0, 1'b0, 1'b1), 0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[8] = '{mk(8'h05, 1'b0, 1'b0, 1'b1), 0, 1'b1, 8'h01, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_pulses", {tx_done, tx_err, rx_err, rx_ovf}, 0);
        check("rst_pads", {ps2_c, ps2_d}, 2'b11);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // lone falling edge: filter latency, then RX timeout
        dev_d = 1'b0;
        dev_c = 1'b0;
        t = 0;
        do begin
            @(posedge clk);
            #1 t++;
        end while (!dut.fall_edge && t < 50);
        check("fall_edge_latency", t, 10);
        repeat (10) @(negedge clk);
        dev_c = 1'b1;
        dev_d = 1'b1;
        repeat (5) @(negedge clk);
        check("tx_ready_mid_frame", tx_ready, 0);
        e0 = n_rxerr;
        t = 0;
        while (n_rxerr == e0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("rx_timeout_err", n_rxerr - e0, 1);
        check("rx_timeout_ready", {tx_ready, rx_valid}, 2'b10);

        // 3-cycle glitch must not produce an edge
        d0 = n_fe;
        @(negedge clk);
        dev_c = 1'b0;
        repeat (3) @(negedge clk);
        dev_c = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_no_edge", n_fe - d0, 0);

        for (int v = 0; v < 9; v++) begin
            e0 = n_rxerr;
            o0 = n_ovf;
            send_frame(vecs[v].frame);
            check($sformatf("v%0d_valid", v), rx_valid, vecs[v].exp_valid);
            if (vecs[v].exp_valid) check($sformatf("v%0d_head", v), rx_data, vecs[v].exp_head);
            check($sformatf("v%0d_err", v), n_rxerr - e0, vecs[v].exp_err);
            check($sformatf("v%0d_ovf", v), n_ovf - o0, vecs[v].exp_ovf);
            repeat (vecs[v].npop) pop_one();
        end
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("pop%0d", k), {rx_valid, rx_data}, {1'b1, 8'(k)});
            pop_one();
        end
        check("fifo_drained", rx_valid, 0);

        // host transmit 0xED with ACK
        e0 = n_txerr;
        d0 = n_done;
        send_cmd(8'hED);
        dev_rx(11, 1'b0, got, low_len, start_bit);
        check("inhibit_len", low_len, 5000);
        check("rts_start_bit", start_bit, 0);
        check("tx_ed_bits", got, 10'h3ED);
        check("tx_ed_done", n_done - d0, 1);
        check("tx_ed_err", n_txerr - e0, 0);
        check("tx_ed_ready", tx_ready, 1);

        // host transmit 0xFF, device NACKs
        e0 = n_txerr;
        d0 = n_done;
        send_cmd(8'hFF);
        dev_rx(11, 1'b1, got, low_len, start_bit);
        check("tx_ff_bits", got, 10'h3FF);
        check("tx_ff_nack_err", n_txerr - e0, 1);
        check("tx_ff_nack_done", n_done - d0, 0);

        // device stops clocking after edge 4
        e0 = n_txerr;
        send_cmd(8'hFF);
        dev_rx(4, 1'b0, got, low_len, start_bit);
        t = 0;
        while (n_txerr == e0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("tx_timeout_err", n_txerr - e0, 1);
        check("tx_timeout_pads", {ps2_c, ps2_d}, 2'b11);
        check("tx_timeout_ready", tx_ready, 1);

        // reset during inhibit releases the pads at once
        send_cmd(8'hA5);
        repeat (100) @(negedge clk);
        check("inhibit_driving", ps2_c, 0);
        rst = 1'b0;
        #1;
        check("rst_mid_tx_pads", {ps2_c, ps2_d}, 2'b11);
        check("rst_mid_tx_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", {tx_ready, ps2_c, ps2_d}, 3'b111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
